// File: rtl/c7bicu_fetch.sv
// Instruction-fetch bridge: one 8-byte fetch at a time from the IFU to the BIU; beats are assembled into a 64-bit packet.
// Optional single-entry line buffer when C7B_ICU_LINEBUF_EN is defined.
module c7bicu_fetch #(
  parameter int BIU_DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_icu_req_ic1,
  input  logic [31:0]       ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  input  logic              ifu_icu_cancel,
  input  logic              ifu_icu_inv,
  output logic              icu_ifu_data_valid_ic2,
  output logic [63:0]       icu_ifu_data_ic2,
  output logic              icu_ifu_err_ic2,
  output logic              icu_biu_req,
  output logic [31:0]       icu_biu_addr,
  input  logic              biu_icu_gnt,
  input  logic              biu_icu_rvalid,
  input  logic [BIU_DW-1:0] biu_icu_rdata,
  input  logic              biu_icu_rerr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [28:0] tag_q, tag_d;
  logic        beat_q, beat_d;
  logic        drop_q, drop_d;
  logic        err_acc_q, err_acc_d;
  logic [31:0] lo_q, lo_d;
  logic        dv_q, dv_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic        ack_c, fill_c, last_beat, lb_hit;
  logic [63:0] pkt, lb_data;

  generate
    if (BIU_DW == 64) begin : g_dw64
      assign last_beat = 1'b1;
      assign pkt       = biu_icu_rdata[63:0];
    end else begin : g_dw32
      // beat0 is parked in lo_q; the final beat completes the packet on the fly
      assign last_beat = beat_q;
      assign pkt       = {biu_icu_rdata[31:0], lo_q};
    end
  endgenerate

`ifdef C7B_ICU_LINEBUF_EN
  logic        lb_v_q;
  logic [28:0] lb_tag_q;
  logic [63:0] lb_data_q;

  assign lb_hit  = lb_v_q && (lb_tag_q == ifu_icu_addr_ic1[31:3]);
  assign lb_data = lb_data_q;

  // an inv coinciding with a fill wins: the entry stays invalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lb_v_q    <= 1'b0;
      lb_tag_q  <= '0;
      lb_data_q <= '0;
    end else if (fill_c) begin
      lb_v_q    <= ~ifu_icu_inv;
      lb_tag_q  <= tag_q;
      lb_data_q <= pkt;
    end else if (ifu_icu_inv) begin
      lb_v_q    <= 1'b0;
    end
  end

  logic unused_lb;
  assign unused_lb = ^ifu_icu_addr_ic1[2:0];
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;

  logic unused_lb;
  assign unused_lb = ^{ifu_icu_addr_ic1[2:0], ifu_icu_inv, fill_c};
`endif

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    beat_d    = beat_q;
    drop_d    = drop_q;
    err_acc_d = err_acc_q;
    lo_d      = lo_q;
    dv_d      = 1'b0;
    data_d    = data_q;
    err_d     = err_q;
    ack_c     = 1'b0;
    fill_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifu_icu_req_ic1) begin
          ack_c = 1'b1;
          if (lb_hit) begin
            dv_d   = 1'b1;
            data_d = lb_data;
            err_d  = 1'b0;
          end else begin
            state_d   = S_REQ;
            tag_d     = ifu_icu_addr_ic1[31:3];
            beat_d    = 1'b0;
            drop_d    = 1'b0;
            err_acc_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (ifu_icu_cancel) drop_d = 1'b1;
        if (biu_icu_gnt) state_d = S_DATA;
      end
      S_DATA: begin
        if (ifu_icu_cancel) drop_d = 1'b1;
        if (biu_icu_rvalid) begin
          err_acc_d = err_acc_q | biu_icu_rerr;
          if (last_beat) begin
            state_d = S_IDLE;
            beat_d  = 1'b0;
            fill_c  = ~(err_acc_q | biu_icu_rerr);
            // a dropped fetch still completes but never updates the visible packet
            if (!(drop_q || ifu_icu_cancel)) begin
              dv_d   = 1'b1;
              data_d = pkt;
              err_d  = err_acc_q | biu_icu_rerr;
            end
          end else begin
            beat_d = 1'b1;
            lo_d   = biu_icu_rdata[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      beat_q    <= 1'b0;
      drop_q    <= 1'b0;
      err_acc_q <= 1'b0;
      lo_q      <= '0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      beat_q    <= beat_d;
      drop_q    <= drop_d;
      err_acc_q <= err_acc_d;
      lo_q      <= lo_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // a cancel in the pulse cycle itself still kills the pulse
  assign icu_ifu_ack_ic1        = ack_c;
  assign icu_ifu_data_valid_ic2 = dv_q & ~ifu_icu_cancel;
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_err_ic2        = err_q;
  assign icu_biu_req            = (state_q == S_REQ);
  assign icu_biu_addr           = {tag_q, 3'b000};

endmodule

// File: tb/tb_c7bicu_fetch.sv
// Bench for c7bicu_fetch: directed scenarios plus random IFU/BIU traffic checked against a transaction-level model.
module tb_c7bicu_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        req, cancel, inv, gnt, rvalid, rerr;
  logic [31:0] addr, rdata;
  logic        ack, dv, err, breq;
  logic [63:0] data;
  logic [31:0] baddr;

  logic        req64, gnt64, rv64, ack64, dv64, err64, breq64;
  logic [31:0] addr64, baddr64;
  logic [63:0] rd64, data64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  c7bicu_fetch #(.BIU_DW(32)) u_dut (
    .clk(clk), .reset(reset),
    .ifu_icu_req_ic1(req), .ifu_icu_addr_ic1(addr), .icu_ifu_ack_ic1(ack),
    .ifu_icu_cancel(cancel), .ifu_icu_inv(inv),
    .icu_ifu_data_valid_ic2(dv), .icu_ifu_data_ic2(data), .icu_ifu_err_ic2(err),
    .icu_biu_req(breq), .icu_biu_addr(baddr), .biu_icu_gnt(gnt),
    .biu_icu_rvalid(rvalid), .biu_icu_rdata(rdata), .biu_icu_rerr(rerr)
  );

  c7bicu_fetch #(.BIU_DW(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .ifu_icu_req_ic1(req64), .ifu_icu_addr_ic1(addr64), .icu_ifu_ack_ic1(ack64),
    .ifu_icu_cancel(1'b0), .ifu_icu_inv(1'b0),
    .icu_ifu_data_valid_ic2(dv64), .icu_ifu_data_ic2(data64), .icu_ifu_err_ic2(err64),
    .icu_biu_req(breq64), .icu_biu_addr(baddr64), .biu_icu_gnt(gnt64),
    .biu_icu_rvalid(rv64), .biu_icu_rdata(rd64), .biu_icu_rerr(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an outstanding fetch (if any), the phase it is waiting on, and the pulse owed next cycle.
  int          ph;       // 0 none outstanding, 1 awaiting grant, 2 awaiting beats
  int          m_nb;
  logic [31:0] m_addr;
  logic [63:0] m_pkt;
  logic        m_drop, m_err;
  logic        pv, pe;
  logic [63:0] pd;
  logic        lbv;
  logic [28:0] lbtag;
  logic [63:0] lbd;

  task automatic model_reset();
    ph = 0; m_nb = 0; m_addr = '0; m_pkt = '0; m_drop = 1'b0; m_err = 1'b0;
    pv = 1'b0; pe = 1'b0; pd = '0; lbv = 1'b0; lbtag = '0; lbd = '0;
  endtask

  function automatic logic lb_hit(input logic [31:0] a);
`ifdef C7B_ICU_LINEBUF_EN
    return lbv && (lbtag == a[31:3]);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic cyc(input logic rq, input logic [31:0] a, input logic cn, input logic g,
                     input logic rv, input logic [31:0] rd, input logic re, input logic iv);
    logic nv, ne, fill;
    logic [63:0] nd;
    @(posedge clk); #1;
    req = rq; addr = a; cancel = cn; gnt = g; rvalid = rv; rdata = rd; rerr = re; inv = iv;
    @(negedge clk);
    chk("ack", {63'd0, ack}, {63'd0, (ph == 0) && rq});
    chk("biu_req", {63'd0, breq}, {63'd0, ph == 1});
    if (ph == 1) chk("biu_addr", {32'd0, baddr}, {32'd0, m_addr});
    chk("data_valid", {63'd0, dv}, {63'd0, pv && !cn});
    if (pv && !cn) begin
      chk("data", data, pd);
      chk("err", {63'd0, err}, {63'd0, pe});
    end
    nv = 1'b0; ne = 1'b0; nd = '0; fill = 1'b0;
    if (ph == 0) begin
      if (rq) begin
        if (lb_hit(a)) begin
          nv = 1'b1; nd = lbd; ne = 1'b0;
        end else begin
          ph = 1; m_addr = {a[31:3], 3'b000}; m_drop = 1'b0; m_err = 1'b0; m_nb = 0;
        end
      end
    end else begin
      if (cn) m_drop = 1'b1;
      if (ph == 1) begin
        if (g) ph = 2;
      end else if (rv) begin
        m_err = m_err | re;
        if (m_nb == 0) m_pkt[31:0] = rd; else m_pkt[63:32] = rd;
        m_nb++;
        if (m_nb == 2) begin
          ph = 0;
          fill = !m_err;
          if (!m_drop) begin nv = 1'b1; nd = m_pkt; ne = m_err; end
        end
      end
    end
`ifdef C7B_ICU_LINEBUF_EN
    if (fill) begin lbv = !iv; lbtag = m_addr[31:3]; lbd = m_pkt; end
    else if (iv) lbv = 1'b0;
`endif
    pv = nv; pd = nd; pe = ne;
  endtask

  task automatic rnd_cycles(input int n);
    logic g, rv;
    for (int i = 0; i < n; i++) begin
      g  = (ph == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      rv = (ph == 2) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 3) != 0, 32'h1c000000 + ($urandom_range(0, 7) << 2),
          $urandom_range(0, 11) == 0, g, rv, $urandom, $urandom_range(0, 7) == 0,
          $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 0; addr = 0; cancel = 0; inv = 0; gnt = 0; rvalid = 0; rdata = 0; rerr = 0;
    req64 = 0; addr64 = 0; gnt64 = 0; rv64 = 0; rd64 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_dv", {63'd0, dv}, 64'd0);
    chk("rst_breq", {63'd0, breq}, 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_baddr", {32'd0, baddr}, 64'd0);
    reset = 1'b0;

    // basic fetch, with the next request held high throughout
    cyc(1, 32'h1c000004, 0, 0, 0, 0, 0, 0);
    chk("t1_ack_c0", {63'd0, ack}, 64'd1);
    cyc(1, 32'h1c000040, 0, 1, 0, 0, 0, 0);
    chk("t1_biu_addr", {32'd0, baddr}, 64'h1c000000);
    chk("t2_noack_c1", {63'd0, ack}, 64'd0);
    cyc(1, 32'h1c000040, 0, 0, 1, 32'h02800000, 0, 0);
    cyc(1, 32'h1c000040, 0, 0, 1, 32'h03400000, 0, 0);
    chk("t2_noack_c3", {63'd0, ack}, 64'd0);
    cyc(1, 32'h1c000040, 0, 0, 0, 0, 0, 0);
    chk("t1_dv_c4", {63'd0, dv}, 64'd1);
    chk("t1_data", data, 64'h03400000_02800000);
    chk("t1_err", {63'd0, err}, 64'd0);
    chk("t2_ack_c4", {63'd0, ack}, 64'd1);

    // cancel after grant: beats absorbed, pulse suppressed
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("t2_biu_addr", {32'd0, baddr}, 64'h1c000040);
    cyc(0, 0, 1, 0, 1, 32'hdeadbeef, 0, 0);
    cyc(1, 32'h1c000080, 0, 0, 1, 32'hcafef00d, 0, 0);
    chk("t3_noack", {63'd0, ack}, 64'd0);
    cyc(1, 32'h1c000080, 0, 0, 0, 0, 0, 0);
    chk("t3_no_dv", {63'd0, dv}, 64'd0);
    chk("t3_ack", {63'd0, ack}, 64'd1);

    // error on beat0 only
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'haaaa5555, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_dv", {63'd0, dv}, 64'd1);
    chk("t4_err", {63'd0, err}, 64'd1);
    chk("t4_data", data, 64'h12345678_aaaa5555);

`ifdef C7B_ICU_LINEBUF_EN
    cyc(1, 32'h1c000000, 0, 0, 0, 0, 0, 0);
    chk("t6_hit_ack", {63'd0, ack}, 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_hit_dv", {63'd0, dv}, 64'd1);
    chk("t6_hit_data", data, 64'h03400000_02800000);
    chk("t6_no_breq", {63'd0, breq}, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h1c000000, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_miss_breq", {63'd0, breq}, 64'd1);
`endif

    rnd_cycles(1500);

    // asynchronous reset in the middle of traffic
    @(posedge clk); #1;
    req = 0; cancel = 0; gnt = 0; rvalid = 0; rerr = 0; inv = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_breq", {63'd0, breq}, 64'd0);
    chk("mid_rst_dv", {63'd0, dv}, 64'd0);
    chk("mid_rst_data", data, 64'd0);
    chk("mid_rst_baddr", {32'd0, baddr}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    rnd_cycles(1500);

    // 64-bit BIU: single beat completes the packet
    @(posedge clk); #1;
    req = 0; cancel = 0; gnt = 0; rvalid = 0; inv = 0;
    req64 = 1; addr64 = 32'h8000123c;
    @(negedge clk);
    chk("t5_ack", {63'd0, ack64}, 64'd1);
    @(posedge clk); #1;
    req64 = 0; gnt64 = 1;
    @(negedge clk);
    chk("t5_breq", {63'd0, breq64}, 64'd1);
    chk("t5_baddr", {32'd0, baddr64}, 64'h80001238);
    @(posedge clk); #1;
    gnt64 = 0; rv64 = 1; rd64 = 64'h11223344_55667788;
    @(negedge clk);
    chk("t5_dv_early", {63'd0, dv64}, 64'd0);
    @(posedge clk); #1;
    rv64 = 0;
    @(negedge clk);
    chk("t5_dv", {63'd0, dv64}, 64'd1);
    chk("t5_data", data64, 64'h11223344_55667788);
    chk("t5_err", {63'd0, err64}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_pulse_1cyc", {63'd0, dv64}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
